// File: rtl/timer_entry_pkg.sv
// Shared encodings for the kitchen-timer entry stage: FSM states,
// digit limits, digit indices and button bit positions.
package timer_entry_pkg;

    typedef enum logic [2:0] {
        EDIT_MU = 3'd0,
        EDIT_ML = 3'd1,
        EDIT_SU = 3'd2,
        EDIT_SL = 3'd3,
        ARMED   = 3'd4
    } state_t;

    localparam logic [3:0] MAX_TENS_SEC = 4'd5;
    localparam logic [3:0] MAX_DIGIT    = 4'd9;

    localparam logic [1:0] DIG_MU = 2'd0;
    localparam logic [1:0] DIG_ML = 2'd1;
    localparam logic [1:0] DIG_SU = 2'd2;
    localparam logic [1:0] DIG_SL = 2'd3;

    localparam int BTN_INC   = 0;
    localparam int BTN_NEXT  = 1;
    localparam int BTN_START = 2;
    localparam int BTN_CLEAR = 3;

    // Seconds tens is the only digit limited to 0..5
    function automatic logic [3:0] digit_max(input logic [1:0] idx);
        return (idx == DIG_SU) ? MAX_TENS_SEC : MAX_DIGIT;
    endfunction

    function automatic logic [3:0] inc_digit(input logic [3:0] d, input logic [3:0] max);
        return (d >= max) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic state_t next_edit(input state_t s);
        case (s)
            EDIT_MU: return EDIT_ML;
            EDIT_ML: return EDIT_SU;
            EDIT_SU: return EDIT_SL;
            default: return EDIT_MU;
        endcase
    endfunction

endpackage

// File: rtl/timer_entry_btn_debounce.sv
// Button conditioner: two-flop synchroniser, consecutive-cycle debounce,
// and a single-cycle rising-edge event on the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic [CW-1:0] r_cnt;

    // Synchronise, then accept a new level only after it has held unbroken
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            if (r_sync2 != r_level) begin
                if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level      = r_level;
    assign rise_pulse = r_level & ~r_level_d;

endmodule

// File: rtl/timer_entry.sv
// Time-entry stage: debounced buttons edit four BCD digits (MM:SS) and
// arm the countdown stage with a one-cycle start pulse.
//
// state   | meaning
// EDIT_MU | editing minutes tens
// EDIT_ML | editing minutes units
// EDIT_SU | editing seconds tens (0..5)
// EDIT_SL | editing seconds units
// ARMED   | entry locked, countdown running downstream
module timer_entry
    import timer_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic [7:0] minutes_upper,
    output logic [7:0] minutes_lower,
    output logic [7:0] seconds_upper,
    output logic [7:0] seconds_lower,
    output logic [1:0] edit_sel,
    output logic       blink,
    output logic       armed,
    output logic       start_pulse
);

    localparam int BW = $clog2(BLINK_CYCLES + 1);

    logic [3:0]    w_raw;
    logic [3:0]    w_level;
    logic [3:0]    w_rise;
    logic          w_all_zero;

    logic [3:0]    r_ev;
    state_t        r_state;
    logic [3:0]    r_digit [4];
    logic [1:0]    r_edit_sel;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink;
    logic          r_armed;
    logic          r_start_pulse;

    assign w_raw = {btn_clear, btn_start, btn_next, btn_inc};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .CLK        (CLK),
            .reset      (reset),
            .raw        (w_raw[g]),
            .level      (w_level[g]),
            .rise_pulse (w_rise[g])
        );
    end

    assign w_all_zero = (r_digit[0] == 4'd0) && (r_digit[1] == 4'd0) &&
                        (r_digit[2] == 4'd0) && (r_digit[3] == 4'd0);

    // Register button events so the FSM sees one clean pulse per press
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_ev <= '0;
        end else begin
            r_ev <= w_rise & w_level;
        end
    end

    // Entry FSM, digit registers and blink indicator; clear > start > next > inc
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state       <= EDIT_MU;
            for (int i = 0; i < 4; i++) r_digit[i] <= 4'd0;
            r_edit_sel    <= DIG_MU;
            r_blink_cnt   <= '0;
            r_blink       <= 1'b0;
            r_armed       <= 1'b0;
            r_start_pulse <= 1'b0;
        end else begin
            r_start_pulse <= 1'b0;

            // Free-running blink while editing; transitions below restart it
            if (r_state != ARMED) begin
                if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
                    r_blink_cnt <= '0;
                    r_blink     <= ~r_blink;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end else begin
                r_blink_cnt <= '0;
                r_blink     <= 1'b0;
            end

            if (r_ev[BTN_CLEAR]) begin
                for (int i = 0; i < 4; i++) r_digit[i] <= 4'd0;
                r_armed    <= 1'b0;
                r_edit_sel <= DIG_MU;
                if (r_state != EDIT_MU) begin
                    r_state     <= EDIT_MU;
                    r_blink_cnt <= '0;
                    r_blink     <= 1'b0;
                end
            end else if (r_ev[BTN_START]) begin
                if (r_state != ARMED && !w_all_zero) begin
                    r_state       <= ARMED;
                    r_armed       <= 1'b1;
                    r_start_pulse <= 1'b1;
                    r_blink_cnt   <= '0;
                    r_blink       <= 1'b0;
                end
            end else if (r_ev[BTN_NEXT]) begin
                if (r_state != ARMED) begin
                    r_state     <= next_edit(r_state);
                    r_edit_sel  <= r_edit_sel + 2'd1;
                    r_blink_cnt <= '0;
                    r_blink     <= 1'b0;
                end
            end else if (r_ev[BTN_INC]) begin
                if (r_state != ARMED) begin
                    r_digit[r_edit_sel] <= inc_digit(r_digit[r_edit_sel], digit_max(r_edit_sel));
                end
            end
        end
    end

    assign minutes_upper = {4'b0000, r_digit[DIG_MU]};
    assign minutes_lower = {4'b0000, r_digit[DIG_ML]};
    assign seconds_upper = {4'b0000, r_digit[DIG_SU]};
    assign seconds_lower = {4'b0000, r_digit[DIG_SL]};
    assign edit_sel      = r_edit_sel;
    assign blink         = r_blink;
    assign armed         = r_armed;
    assign start_pulse   = r_start_pulse;

endmodule

// File: tb/tb_timer_entry.sv
// Bench for timer_entry: directed steps plus random button presses,
// compared against a press-level model of the entry rules.
module tb_timer_entry;

    localparam int DB = 4;
    localparam int BL = 8;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic [7:0] minutes_upper, minutes_lower, seconds_upper, seconds_lower;
    logic [1:0] edit_sel;
    logic       blink, armed, start_pulse;

    int errors = 0;
    int checks = 0;

    // press-level model
    int  m_d [4];
    int  m_sel;
    bit  m_armed;
    int  m_arms;

    int  pulse_cnt = 0;
    int  pulse_double = 0;
    bit  prev_pulse = 1'b0;

    timer_entry #(.DEBOUNCE_CYCLES(DB), .BLINK_CYCLES(BL)) dut (
        .CLK           (CLK),
        .reset         (reset),
        .btn_next      (btn_next),
        .btn_inc       (btn_inc),
        .btn_start     (btn_start),
        .btn_clear     (btn_clear),
        .minutes_upper (minutes_upper),
        .minutes_lower (minutes_lower),
        .seconds_upper (seconds_upper),
        .seconds_lower (seconds_lower),
        .edit_sel      (edit_sel),
        .blink         (blink),
        .armed         (armed),
        .start_pulse   (start_pulse)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (start_pulse === 1'b1) begin
            pulse_cnt++;
            if (prev_pulse) pulse_double++;
        end
        prev_pulse = (start_pulse === 1'b1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_d[i] = 0;
        m_sel = 0;
        m_armed = 1'b0;
    endtask

    // mask bits: 0 inc, 1 next, 2 start, 3 clear; only the top-priority one acts
    task automatic model_apply(input logic [3:0] mask);
        if (mask[3]) begin
            for (int i = 0; i < 4; i++) m_d[i] = 0;
            m_sel = 0;
            m_armed = 1'b0;
        end else if (mask[2]) begin
            if (!m_armed && (m_d[0] + m_d[1] + m_d[2] + m_d[3]) != 0) begin
                m_armed = 1'b1;
                m_arms++;
            end
        end else if (mask[1]) begin
            if (!m_armed) m_sel = (m_sel + 1) % 4;
        end else if (mask[0]) begin
            if (!m_armed) m_d[m_sel] = (m_d[m_sel] + 1) % ((m_sel == 2) ? 6 : 10);
        end
    endtask

    task automatic drive(input logic [3:0] mask);
        btn_inc   = mask[0];
        btn_next  = mask[1];
        btn_start = mask[2];
        btn_clear = mask[3];
    endtask

    task automatic press(input logic [3:0] mask);
        drive(mask);
        tick(10);
        drive(4'b0000);
        tick(10);
        model_apply(mask);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_mu"}, minutes_upper, m_d[0]);
        check({tag, "_ml"}, minutes_lower, m_d[1]);
        check({tag, "_su"}, seconds_upper, m_d[2]);
        check({tag, "_sl"}, seconds_lower, m_d[3]);
        check({tag, "_armed"}, armed, m_armed);
        check({tag, "_pulses"}, pulse_cnt, m_arms);
        if (m_armed) check({tag, "_blink_armed"}, blink, 0);
        else         check({tag, "_sel"}, edit_sel, m_sel);
    endtask

    initial begin
        int c;
        int t_sel;
        logic [1:0] old_sel;
        logic [3:0] mask;
        int op;

        m_arms = 0;
        model_reset();

        // reset and idle
        tick(3);
        reset = 1'b0;
        tick(50);
        check_all("reset");
        check("reset_blink_idle_ok", (blink === 1'b0 || blink === 1'b1), 1);

        // directed digit entry
        repeat (3) press(4'b0001);
        press(4'b0010);
        repeat (2) press(4'b0001);
        press(4'b0010);
        repeat (7) press(4'b0001);
        check_all("entry");
        check("entry_mu3", minutes_upper, 3);
        check("entry_su_wrap", seconds_upper, 1);
        check("entry_sel2", edit_sel, 2);

        // short glitches on inc are rejected
        repeat (5) begin
            btn_inc = 1'b1;
            tick(2);
            btn_inc = 1'b0;
            tick(8);
        end
        check_all("glitch");

        // blink restarts on a digit change: rises BL cycles later, falls BL after
        old_sel = edit_sel;
        btn_next = 1'b1;
        t_sel = -1;
        for (int k = 0; k < 30 && t_sel < 0; k++) begin
            tick();
            if (edit_sel !== old_sel) t_sel = k;
        end
        check("blink_sel_changed", (t_sel >= 0), 1);
        check("blink_zero_on_change", blink, 0);
        c = 0;
        while (blink !== 1'b1 && c < 20) begin tick(); c++; end
        check("blink_first_rise", c, BL);
        c = 0;
        while (blink !== 1'b0 && c < 20) begin tick(); c++; end
        check("blink_half_period", c, BL);
        btn_next = 1'b0;
        tick(10);
        model_apply(4'b0010);
        check_all("blink_next_once");

        // start from 00:00 ignored, then arm with 00:05
        press(4'b1000);
        press(4'b0100);
        check_all("start_zero");
        repeat (3) press(4'b0010);
        repeat (5) press(4'b0001);
        press(4'b0100);
        check_all("armed");
        check("armed_sl5", seconds_lower, 5);
        check("armed_flag", armed, 1);

        // locked while armed, then clear
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        check_all("armed_locked");
        press(4'b1000);
        check_all("armed_clear");

        // start and clear together: clear wins
        press(4'b0001);
        press(4'b1100);
        check_all("start_clear");

        // reset mid-debounce of inc, with nonzero digits present
        press(4'b0001);
        press(4'b0001);
        btn_inc = 1'b1;
        tick(3);
        reset = 1'b1;
        #1;
        check("async_reset_mu", minutes_upper, 0);
        tick(2);
        btn_inc = 1'b0;
        reset = 1'b0;
        model_reset();
        tick(20);
        check_all("reset_mid_db");

        // reset while armed
        press(4'b0001);
        press(4'b0100);
        check_all("pre_reset_armed");
        reset = 1'b1;
        #1;
        check("async_reset_armed", armed, 0);
        tick(2);
        reset = 1'b0;
        model_reset();
        tick(5);
        check_all("reset_armed");

        // random presses against the model
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 4)      mask = 4'b0001;
            else if (op <= 6) mask = 4'b0010;
            else if (op == 7) mask = 4'b0100;
            else if (op == 8) mask = ($urandom_range(0, 3) == 0) ? 4'b1000 : 4'b0001;
            else              mask = 4'($urandom_range(1, 15));
            press(mask);
            check_all("rand");
        end

        check("pulse_single_cycle", pulse_double, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
